// File: rtl/mux_sweep_checker.sv
// Clocked exhaustive sweep of a 2:1 mux (z = c ? b : a): drives all 8 {a,b,c}
// vectors, samples z after a settle window and accumulates a pass/fail summary.
module mux_sweep_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       z,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic       fail_seen,
    output logic [2:0] first_fail_vec
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       exp_z;
    logic       mismatch;

    assign exp_z    = c ? b : a;
    // Case-inequality so an undriven or unknown z is scored as a failure.
    assign mismatch = (z !== exp_z);
    assign pass     = done & (fail_count == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            {a, b, c}      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail_count     <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx            <= '0;
                        {a, b, c}      <= '0;
                        cnt            <= RELOAD;
                        fail_count     <= '0;
                        fail_seen      <= 1'b0;
                        first_fail_vec <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= CHECK;
                    else             cnt   <= cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + 4'd1;
                        if (!fail_seen) begin
                            fail_seen      <= 1'b1;
                            first_fail_vec <= {a, b, c};
                        end
                    end
                    if (idx == 3'd7) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx       <= idx + 3'd1;
                        {a, b, c} <= idx + 3'd1;
                        cnt       <= RELOAD;
                        state     <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: two instances (settle 1 and 3) each driving a
// behavioural mux whose fault mode is selectable; final results are scoreboarded.
module tb_mux_sweep_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] z_v;
    logic [1:0] a_v, b_v, c_v, busy_v, done_v, pass_v, seen_v;
    logic [1:0][3:0] fc_v;
    logic [1:0][2:0] first_v;
    int fault = 0;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        int fc;
        int seen;
        int first;
    } res_t;
    res_t sb[$];

    always #5 clk = ~clk;

    mux_sweep_checker #(.SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .z(z_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail_count(fc_v[0]), .fail_seen(seen_v[0]),
        .first_fail_vec(first_v[0])
    );

    mux_sweep_checker #(.SETTLE_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .z(z_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail_count(fc_v[1]), .fail_seen(seen_v[1]),
        .first_fail_vec(first_v[1])
    );

    // 0: correct mux, 1: z stuck at 0, 2: select ignored (z = a)
    function automatic logic mut(input logic ia, input logic ib, input logic ic, input int f);
        case (f)
            1:       return 1'b0;
            2:       return ia;
            default: return ic ? ib : ia;
        endcase
    endfunction

    always_comb z_v[0] = mut(a_v[0], b_v[0], c_v[0], fault);
    always_comb z_v[1] = mut(a_v[1], b_v[1], c_v[1], fault);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        ncmp++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_abc"},   {29'd0, a_v[d], b_v[d], c_v[d]}, 0);
        chk({tag, "_busy"},  {31'd0, busy_v[d]}, 0);
        chk({tag, "_done"},  {31'd0, done_v[d]}, 0);
        chk({tag, "_pass"},  {31'd0, pass_v[d]}, 0);
        chk({tag, "_fc"},    {28'd0, fc_v[d]}, 0);
        chk({tag, "_seen"},  {31'd0, seen_v[d]}, 0);
        chk({tag, "_first"}, {29'd0, first_v[d]}, 0);
    endtask

    // Run one full sweep on instance d with fault mode f; poke adds start
    // pulses while busy, which must not disturb the sequence.
    task automatic sweep(input int d, input int f, input bit poke);
        int s, total, vi;
        res_t r, e;
        logic [2:0] v;
        logic ez, zz;
        s = (d == 0) ? 1 : 3;
        total = 8 * (s + 1);
        r = '{fc: 0, seen: 0, first: 0};
        for (int i = 0; i < 8; i++) begin
            v  = 3'(i);
            ez = v[0] ? v[1] : v[2];
            zz = mut(v[2], v[1], v[0], f);
            if (zz !== ez) begin
                r.fc++;
                if (r.seen == 0) begin
                    r.seen  = 1;
                    r.first = i;
                end
            end
        end
        sb.push_back(r);
        fault = f;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int j = 0; j <= total; j++) begin
            if (j == 0) begin
                chk("clr_fc",   {28'd0, fc_v[d]}, 0);
                chk("clr_seen", {31'd0, seen_v[d]}, 0);
                chk("clr_done", {31'd0, done_v[d]}, 0);
            end
            if (j < total) begin
                vi = j / (s + 1);
                chk("vec",  {29'd0, a_v[d], b_v[d], c_v[d]}, vi);
                chk("busy", {31'd0, busy_v[d]}, 1);
                chk("done_early", {31'd0, done_v[d]}, 0);
            end else begin
                chk("done_at", {31'd0, done_v[d]}, 1);
                chk("busy_end", {31'd0, busy_v[d]}, 0);
                e = sb.pop_front();
                chk("fail_count", {28'd0, fc_v[d]}, e.fc);
                chk("fail_seen",  {31'd0, seen_v[d]}, e.seen);
                if (e.seen != 0) chk("first_fail_vec", {29'd0, first_v[d]}, e.first);
                chk("pass", {31'd0, pass_v[d]}, (e.fc == 0) ? 1 : 0);
            end
            if (poke) start_v[d] = (j == 3 || j == 10 || j == 21);
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        chk("done_hold", {31'd0, done_v[d]}, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");

        sweep(0, 0, 1'b0);   // correct mux
        sweep(0, 1, 1'b0);   // stuck-at-0: 4 failures, first 011
        sweep(0, 0, 1'b0);   // restart from DONE after a failing sweep
        sweep(0, 2, 1'b0);   // select ignored: 2 failures, first 011
        sweep(1, 0, 1'b1);   // long settle, start pokes while busy

        // Reset mid-sweep
        fault = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", {31'd0, busy_v[0]}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero(0, "midrst");
        @(negedge clk);
        chk_zero(0, "idle_hold");
        sweep(0, 0, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
